// File: rtl/otter_pkg.sv
// Shared OTTER definitions: register-index and data-word types used across the
// operand-read path.
package otter_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/otter_scoreboard.sv
// Per-register pending-write scoreboard. Each architectural register carries a
// small counter of writes that have been issued but not yet written back.
module otter_scoreboard
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_idx_i,
    input  logic [4:0]       rs2_idx_i,
    input  logic [4:0]       rd_idx_i,
    output logic [CNT_W-1:0] rs1_cnt_o,
    output logic [CNT_W-1:0] rs2_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    input  logic             inc_i,
    input  logic [4:0]       inc_idx_i,
    input  logic             wb_i,
    input  logic [4:0]       wb_idx_i,
    output logic             wb_err_o
);
    import otter_pkg::*;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];

    assign rs1_cnt_o = cnt_q[rs1_idx_i];
    assign rs2_cnt_o = cnt_q[rs2_idx_i];
    assign rd_cnt_o  = cnt_q[rd_idx_i];

    // A write-back to a non-zero register with nothing pending is a tracking error.
    assign wb_err_o  = wb_i && (wb_idx_i != '0) && (cnt_q[wb_idx_i] == '0);

    // Next count per register; simultaneous issue and retire of one register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NREGS; r++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit = inc_i && (reg_idx_t'(inc_idx_i) == REG_IDX_W'(r));
            dec_hit = wb_i  && (reg_idx_t'(wb_idx_i)  == REG_IDX_W'(r)) && (cnt_q[r] != '0);
            if (inc_hit && !dec_hit) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Counter array; reset discards all in-flight tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/otter_operand_reader.sv
// OTTER operand reader: reads the register file for decode, stalls on RAW
// hazards tracked by the scoreboard, forwards the retiring write-back value,
// and registers resolved operands toward execute behind a valid/ready handshake.
module otter_operand_reader
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
)(
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               ISSUE_VALID,
    input  logic [4:0]         ISSUE_RS1,
    input  logic [4:0]         ISSUE_RS2,
    input  logic               ISSUE_USES_RS1,
    input  logic               ISSUE_USES_RS2,
    input  logic [4:0]         ISSUE_RD,
    input  logic               ISSUE_WRITES_RD,
    output logic               ISSUE_READY,
    output logic [4:0]         RF_ADR1,
    output logic [4:0]         RF_ADR2,
    input  logic [XLEN-1:0]    RF_RS1,
    input  logic [XLEN-1:0]    RF_RS2,
    input  logic               WB_VALID,
    input  logic [4:0]         WB_RD,
    input  logic [XLEN-1:0]    WB_DATA,
    output logic               OP_VALID,
    input  logic               OP_READY,
    output logic [XLEN-1:0]    OP_A,
    output logic [XLEN-1:0]    OP_B,
    output logic [4:0]         OP_RD,
    output logic               SB_ERR,
    output logic [STALL_W-1:0] STALL_CNT
);
    import otter_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A source is clear when nothing is pending, or when the only pending write retires now.
    function automatic logic src_clear(input logic [CNT_W-1:0] cnt, input reg_idx_t idx,
                                       input logic wb_v, input reg_idx_t wb_idx);
        return (cnt == '0) || ((cnt == CNT_W'(1)) && wb_v && (wb_idx == idx));
    endfunction

    // Operand value: x0 reads zero, idle registers read the file, otherwise the forward.
    function automatic logic [XLEN-1:0] src_value(input reg_idx_t idx, input logic [CNT_W-1:0] cnt,
                                                  input logic [XLEN-1:0] rf, input logic [XLEN-1:0] wb);
        if (idx == '0)      return '0;
        else if (cnt == '0) return rf;
        else                return wb;
    endfunction

    // Stall counter sticks at all-ones rather than wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    logic [CNT_W-1:0]   rs1_cnt, rs2_cnt, rd_cnt;
    logic               wb_err, inc_en;
    logic               haz1, haz2, hazard, sat_block, accept;
    logic [XLEN-1:0]    val1, val2;

    logic               op_valid_q, op_valid_d;
    logic [XLEN-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [4:0]         op_rd_q, op_rd_d;
    logic               sb_err_q, sb_err_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    assign RF_ADR1 = ISSUE_RS1;
    assign RF_ADR2 = ISSUE_RS2;

    otter_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk_i     (CLOCK),
        .rst_i     (RESET),
        .rs1_idx_i (ISSUE_RS1),
        .rs2_idx_i (ISSUE_RS2),
        .rd_idx_i  (ISSUE_RD),
        .rs1_cnt_o (rs1_cnt),
        .rs2_cnt_o (rs2_cnt),
        .rd_cnt_o  (rd_cnt),
        .inc_i     (inc_en),
        .inc_idx_i (ISSUE_RD),
        .wb_i      (WB_VALID),
        .wb_idx_i  (WB_RD),
        .wb_err_o  (wb_err)
    );

    // Hazard, saturation block and issue handshake, all on pre-issue counts.
    always_comb begin
        haz1      = ISSUE_USES_RS1 && (ISSUE_RS1 != '0) && !src_clear(rs1_cnt, ISSUE_RS1, WB_VALID, WB_RD);
        haz2      = ISSUE_USES_RS2 && (ISSUE_RS2 != '0) && !src_clear(rs2_cnt, ISSUE_RS2, WB_VALID, WB_RD);
        hazard    = haz1 || haz2;
        sat_block = ISSUE_WRITES_RD && (ISSUE_RD != '0) && (rd_cnt == CNT_MAX)
                    && !(WB_VALID && (WB_RD == ISSUE_RD));
        ISSUE_READY = !hazard && !sat_block && (!op_valid_q || OP_READY);
        accept    = ISSUE_VALID && ISSUE_READY;
        inc_en    = accept && ISSUE_WRITES_RD && (ISSUE_RD != '0);
        val1      = src_value(ISSUE_RS1, rs1_cnt, RF_RS1, WB_DATA);
        val2      = src_value(ISSUE_RS2, rs2_cnt, RF_RS2, WB_DATA);
    end

    // Next state of the execute-side register, error flag and stall counter.
    always_comb begin
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_rd_d    = op_rd_q;
        if (accept) begin
            op_valid_d = 1'b1;
            op_a_d     = val1;
            op_b_d     = val2;
            op_rd_d    = ISSUE_RD;
        end else if (OP_READY) begin
            op_valid_d = 1'b0;
        end
        sb_err_d = sb_err_q || wb_err;
        stall_d  = (ISSUE_VALID && hazard) ? sat_inc(stall_q) : stall_q;
    end

    // State registers toward execute plus status.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            sb_err_q   <= 1'b0;
            stall_q    <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_rd_q    <= op_rd_d;
            sb_err_q   <= sb_err_d;
            stall_q    <= stall_d;
        end
    end

    assign OP_VALID  = op_valid_q;
    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign OP_RD     = op_rd_q;
    assign SB_ERR    = sb_err_q;
    assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_otter_operand_reader.sv
// Self-checking bench for otter_operand_reader: directed scenarios plus a
// randomized run against a pending-write reference model.
module tb_otter_operand_reader;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 2;
    localparam int STALL_W = 16;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic               CLOCK = 1'b0;
    logic               RESET = 1'b1;
    logic               ISSUE_VALID, ISSUE_USES_RS1, ISSUE_USES_RS2, ISSUE_WRITES_RD;
    logic [4:0]         ISSUE_RS1, ISSUE_RS2, ISSUE_RD;
    logic               ISSUE_READY;
    logic [4:0]         RF_ADR1, RF_ADR2;
    logic [XLEN-1:0]    RF_RS1, RF_RS2;
    logic               WB_VALID;
    logic [4:0]         WB_RD;
    logic [XLEN-1:0]    WB_DATA;
    logic               OP_VALID, OP_READY;
    logic [XLEN-1:0]    OP_A, OP_B;
    logic [4:0]         OP_RD;
    logic               SB_ERR;
    logic [STALL_W-1:0] STALL_CNT;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          pend [32];
    bit          m_vld, m_u1, m_u2, m_err;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    int          m_stall;

    otter_operand_reader #(.XLEN(XLEN), .NREGS(32), .CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
        .ISSUE_USES_RS1(ISSUE_USES_RS1), .ISSUE_USES_RS2(ISSUE_USES_RS2),
        .ISSUE_RD(ISSUE_RD), .ISSUE_WRITES_RD(ISSUE_WRITES_RD), .ISSUE_READY(ISSUE_READY),
        .RF_ADR1(RF_ADR1), .RF_ADR2(RF_ADR2), .RF_RS1(RF_RS1), .RF_RS2(RF_RS2),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_A(OP_A), .OP_B(OP_B), .OP_RD(OP_RD),
        .SB_ERR(SB_ERR), .STALL_CNT(STALL_CNT)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic bit m_haz(input bit uses, input int rs);
        if (!uses || rs == 0) return 0;
        if (pend[rs] == 0) return 0;
        if (pend[rs] == 1 && WB_VALID && int'(WB_RD) == rs) return 0;
        return 1;
    endfunction

    function automatic bit m_ready();
        bit sat;
        sat = ISSUE_WRITES_RD && ISSUE_RD != 0 && pend[ISSUE_RD] == MAXC
              && !(WB_VALID && WB_RD == ISSUE_RD);
        return !m_haz(ISSUE_USES_RS1, int'(ISSUE_RS1)) && !m_haz(ISSUE_USES_RS2, int'(ISSUE_RS2))
               && !sat && (!m_vld || OP_READY);
    endfunction

    function automatic logic [31:0] m_val(input int rs, input logic [31:0] rf);
        if (rs == 0) return 32'h0;
        if (pend[rs] == 0) return rf;
        return WB_DATA;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_vld = 0; m_u1 = 0; m_u2 = 0; m_err = 0; m_a = 0; m_b = 0; m_rd = 0; m_stall = 0;
    endtask

    task automatic idle();
        ISSUE_VALID = 0; ISSUE_RS1 = 0; ISSUE_RS2 = 0; ISSUE_USES_RS1 = 0; ISSUE_USES_RS2 = 0;
        ISSUE_RD = 0; ISSUE_WRITES_RD = 0; RF_RS1 = 0; RF_RS2 = 0;
        WB_VALID = 0; WB_RD = 0; WB_DATA = 0; OP_READY = 1;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit acc, hz;
        logic [31:0] na, nb;
        hz  = m_haz(ISSUE_USES_RS1, int'(ISSUE_RS1)) || m_haz(ISSUE_USES_RS2, int'(ISSUE_RS2));
        acc = ISSUE_VALID && m_ready();
        na  = m_val(int'(ISSUE_RS1), RF_RS1);
        nb  = m_val(int'(ISSUE_RS2), RF_RS2);
        if (ISSUE_VALID && hz && m_stall < SMAX) m_stall++;
        if (WB_VALID && WB_RD != 0) begin
            if (pend[WB_RD] == 0) m_err = 1;
            else pend[WB_RD]--;
        end
        if (acc && ISSUE_WRITES_RD && ISSUE_RD != 0) pend[ISSUE_RD]++;
        if (acc) begin
            m_vld = 1; m_a = na; m_b = nb; m_rd = ISSUE_RD;
            m_u1 = ISSUE_USES_RS1; m_u2 = ISSUE_USES_RS2;
        end else if (OP_READY) begin
            m_vld = 0;
        end
        @(posedge CLOCK); #1;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1;
        #1;
        model_clear();
        @(posedge CLOCK); #1;
        RESET = 0;
    endtask

    task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr);
        ISSUE_VALID = 1; ISSUE_RS1 = 5'(rs1); ISSUE_USES_RS1 = u1; ISSUE_RS2 = 5'(rs2);
        ISSUE_USES_RS2 = u2; ISSUE_RD = 5'(rd); ISSUE_WRITES_RD = wr;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1;
        #2;
        checks++; if (OP_VALID !== 1'b0) begin errors++; $display("FAIL reset_op_valid got=%0b want=0", OP_VALID); end
        checks++; if (OP_A !== 32'h0 || OP_B !== 32'h0) begin errors++; $display("FAIL reset_ops got=%h/%h want=0/0", OP_A, OP_B); end
        checks++; if (OP_RD !== 5'd0) begin errors++; $display("FAIL reset_op_rd got=%0d want=0", OP_RD); end
        checks++; if (SB_ERR !== 1'b0) begin errors++; $display("FAIL reset_sb_err got=%0b want=0", SB_ERR); end
        checks++; if (STALL_CNT !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", STALL_CNT); end
        do_reset();
        issue(5, 1, 6, 1, 7, 1);
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", ISSUE_READY); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(0, 0, 0, 0, 5, 1);
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got=%0b want=1", ISSUE_READY); end
        tick();
        issue(6, 1, 0, 0, 8, 0);
        RF_RS1 = 32'h11;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL b2b_second_ready got=%0b want=1", ISSUE_READY); end
        checks++; if (RF_ADR1 !== 5'd6) begin errors++; $display("FAIL b2b_rf_adr1 got=%0d want=6", RF_ADR1); end
        tick();
        idle();
        checks++; if (OP_VALID !== 1'b1 || OP_A !== 32'h11) begin errors++; $display("FAIL b2b_op_a got=%0b/%h want=1/00000011", OP_VALID, OP_A); end
    endtask

    task automatic test_raw_forward();
        do_reset();
        issue(0, 0, 0, 0, 5, 1);
        tick();
        issue(5, 1, 0, 0, 1, 0);
        RF_RS1 = 32'h5555;
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL raw_stall_ready got=%0b want=0", ISSUE_READY); end
        tick();
        checks++; if (STALL_CNT !== 16'd1) begin errors++; $display("FAIL raw_stall_cnt got=%0d want=1", STALL_CNT); end
        WB_VALID = 1; WB_RD = 5; WB_DATA = 32'hDEADBEEF;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL raw_fwd_ready got=%0b want=1", ISSUE_READY); end
        tick();
        idle();
        checks++; if (OP_VALID !== 1'b1 || OP_A !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_fwd_op_a got=%0b/%h want=1/deadbeef", OP_VALID, OP_A); end
        checks++; if (STALL_CNT !== 16'd1) begin errors++; $display("FAIL raw_stall_hold got=%0d want=1", STALL_CNT); end
        tick();
        issue(5, 1, 0, 0, 0, 0);
        RF_RS1 = 32'h1234;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL raw_drained_ready got=%0b want=1", ISSUE_READY); end
        tick();
        idle();
        checks++; if (OP_A !== 32'h1234) begin errors++; $display("FAIL raw_drained_op_a got=%h want=00001234", OP_A); end
    endtask

    task automatic test_two_writers();
        do_reset();
        issue(0, 0, 0, 0, 7, 1);
        tick();
        tick();
        issue(0, 0, 7, 1, 3, 0);
        WB_VALID = 1; WB_RD = 7; WB_DATA = 32'h1111;
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL two_wr_first_wb got=%0b want=0", ISSUE_READY); end
        tick();
        WB_VALID = 0;
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL two_wr_still_stall got=%0b want=0", ISSUE_READY); end
        tick();
        WB_VALID = 1; WB_RD = 7; WB_DATA = 32'hCAFE;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL two_wr_final_ready got=%0b want=1", ISSUE_READY); end
        tick();
        idle();
        checks++; if (OP_B !== 32'hCAFE || OP_RD !== 5'd3) begin errors++; $display("FAIL two_wr_op_b got=%h/%0d want=0000cafe/3", OP_B, OP_RD); end
        checks++; if (STALL_CNT !== 16'd2) begin errors++; $display("FAIL two_wr_stall got=%0d want=2", STALL_CNT); end
    endtask

    task automatic test_saturation();
        do_reset();
        issue(0, 0, 0, 0, 9, 1);
        for (int i = 0; i < MAXC; i++) tick();
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL sat_block got=%0b want=0", ISSUE_READY); end
        WB_VALID = 1; WB_RD = 9; WB_DATA = 32'h9;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL sat_wb_ready got=%0b want=1", ISSUE_READY); end
        tick();
        WB_VALID = 0;
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL sat_count_kept got=%0b want=0", ISSUE_READY); end
        checks++; if (STALL_CNT !== 16'd0 || SB_ERR !== 1'b0) begin errors++; $display("FAIL sat_status got=%0d/%0b want=0/0", STALL_CNT, SB_ERR); end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        issue(1, 1, 0, 0, 2, 0);
        RF_RS1 = 32'hA5; OP_READY = 0;
        tick();
        issue(1, 1, 0, 0, 4, 0);
        RF_RS1 = 32'h5A;
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL bp_ready got=%0b want=0", ISSUE_READY); end
        tick();
        tick();
        checks++; if (OP_VALID !== 1'b1 || OP_A !== 32'hA5 || OP_RD !== 5'd2) begin errors++; $display("FAIL bp_hold got=%0b/%h/%0d want=1/000000a5/2", OP_VALID, OP_A, OP_RD); end
        OP_READY = 1;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b want=1", ISSUE_READY); end
        tick();
        idle();
        checks++; if (OP_A !== 32'h5A || OP_RD !== 5'd4) begin errors++; $display("FAIL bp_next got=%h/%0d want=0000005a/4", OP_A, OP_RD); end
        tick();
        checks++; if (OP_VALID !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b want=0", OP_VALID); end
    endtask

    task automatic test_x0_and_error();
        do_reset();
        issue(0, 1, 0, 1, 0, 1);
        RF_RS1 = 32'hFFFF; RF_RS2 = 32'hFFFF;
        tick();
        idle();
        checks++; if (OP_A !== 32'h0 || OP_B !== 32'h0) begin errors++; $display("FAIL x0_operand got=%h/%h want=0/0", OP_A, OP_B); end
        WB_VALID = 1; WB_RD = 0; WB_DATA = 32'h77;
        tick();
        checks++; if (SB_ERR !== 1'b0) begin errors++; $display("FAIL x0_wb_no_err got=%0b want=0", SB_ERR); end
        WB_RD = 3;
        tick();
        idle();
        checks++; if (SB_ERR !== 1'b1) begin errors++; $display("FAIL err_set got=%0b want=1", SB_ERR); end
        issue(0, 0, 0, 0, 3, 1);
        tick();
        idle();
        tick();
        checks++; if (SB_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b want=1", SB_ERR); end
        issue(0, 0, 0, 0, 6, 0);
        tick();
        idle();
        OP_READY = 0;
        RESET = 1;
        #1;
        checks++; if (SB_ERR !== 1'b0 || OP_VALID !== 1'b0) begin errors++; $display("FAIL async_reset got=%0b/%0b want=0/0", SB_ERR, OP_VALID); end
        model_clear();
        @(posedge CLOCK); #1;
        RESET = 0;
        issue(3, 1, 0, 0, 0, 0);
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL reset_clears_pend got=%0b want=1", ISSUE_READY); end
        idle();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ISSUE_VALID     = ($urandom_range(0, 3) != 0);
            ISSUE_RS1       = 5'($urandom_range(0, 7));
            ISSUE_RS2       = 5'($urandom_range(0, 7));
            ISSUE_USES_RS1  = $urandom_range(0, 1);
            ISSUE_USES_RS2  = $urandom_range(0, 1);
            ISSUE_RD        = 5'($urandom_range(0, 7));
            ISSUE_WRITES_RD = ($urandom_range(0, 2) != 0);
            RF_RS1          = $urandom;
            RF_RS2          = $urandom;
            OP_READY        = ($urandom_range(0, 3) != 0);
            r               = $urandom_range(1, 7);
            WB_VALID        = (pend[r] > 0 && $urandom_range(0, 2) != 0) || ($urandom_range(0, 79) == 0);
            WB_RD           = 5'(r);
            WB_DATA         = $urandom;
            #1;
            checks++; if (ISSUE_READY !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", n, ISSUE_READY, m_ready()); end
            checks++; if (RF_ADR2 !== ISSUE_RS2) begin errors++; $display("FAIL rnd_rf_adr2 cyc=%0d got=%0d want=%0d", n, RF_ADR2, ISSUE_RS2); end
            tick();
            checks++; if (OP_VALID !== m_vld) begin errors++; $display("FAIL rnd_op_valid cyc=%0d got=%0b want=%0b", n, OP_VALID, m_vld); end
            if (m_vld) begin
                checks++; if (OP_RD !== m_rd) begin errors++; $display("FAIL rnd_op_rd cyc=%0d got=%0d want=%0d", n, OP_RD, m_rd); end
                if (m_u1) begin
                    checks++; if (OP_A !== m_a) begin errors++; $display("FAIL rnd_op_a cyc=%0d got=%h want=%h", n, OP_A, m_a); end
                end
                if (m_u2) begin
                    checks++; if (OP_B !== m_b) begin errors++; $display("FAIL rnd_op_b cyc=%0d got=%h want=%h", n, OP_B, m_b); end
                end
            end
            checks++; if (SB_ERR !== m_err) begin errors++; $display("FAIL rnd_sb_err cyc=%0d got=%0b want=%0b", n, SB_ERR, m_err); end
            checks++; if (int'(STALL_CNT) != m_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d want=%0d", n, STALL_CNT, m_stall); end
        end
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_back_to_back();
        test_raw_forward();
        test_two_writers();
        test_saturation();
        test_backpressure();
        test_x0_and_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
